// File: rtl/exec_pkg.sv
// Shared opcodes, FSM/decode enums and instruction field positions for the
// execute-stage controller.
package exec_pkg;

  localparam logic [5:0] OP_LDI  = 6'd0;
  localparam logic [5:0] OP_MOV  = 6'd1;
  localparam logic [5:0] OP_LD   = 6'd2;
  localparam logic [5:0] OP_ST   = 6'd3;
  localparam logic [5:0] OP_ADD  = 6'd4;
  localparam logic [5:0] OP_SUB  = 6'd5;
  localparam logic [5:0] OP_NEG  = 6'd6;
  localparam logic [5:0] OP_MUL  = 6'd7;
  localparam logic [5:0] OP_AND  = 6'd8;
  localparam logic [5:0] OP_OR   = 6'd9;
  localparam logic [5:0] OP_XOR  = 6'd10;
  localparam logic [5:0] OP_NAND = 6'd11;
  localparam logic [5:0] OP_NOR  = 6'd12;
  localparam logic [5:0] OP_XNOR = 6'd13;
  localparam logic [5:0] OP_NOT  = 6'd14;
  localparam logic [5:0] OP_SHL  = 6'd15;
  localparam logic [5:0] OP_SHR  = 6'd16;

  localparam int F_OPC_HI   = 31, F_OPC_LO   = 26;
  localparam int F_RDST2_HI = 25, F_RDST2_LO = 21;
  localparam int F_RDST1_HI = 20, F_RDST1_LO = 16;
  localparam int F_RSRC2_HI = 9,  F_RSRC2_LO = 5;
  localparam int F_RSRC1_HI = 4,  F_RSRC1_LO = 0;
  localparam int F_IMM_HI   = 15, F_IMM_LO   = 0;
  localparam int F_LDA_HI   = 7,  F_LDA_LO   = 0;
  localparam int F_STA_HI   = 25, F_STA_LO   = 18;

  localparam int unsigned MUL_LAT_MIN = 1;
  localparam int unsigned MUL_LAT_MAX = 15;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_MEM, S_WB1, S_WB2} state_t;
  typedef enum logic [2:0] {C_LDI, C_MOV, C_LD, C_ST, C_ALU, C_MUL, C_ILL} iclass_t;

endpackage

// File: rtl/exec_decode.sv
// Combinational instruction decode: class, register fields, memory addresses
// and immediate.
module exec_decode
  import exec_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  cls,
  output logic [4:0]  alu_op,
  output logic [4:0]  rdst2,
  output logic [4:0]  rdst1,
  output logic [4:0]  rsrc2,
  output logic [4:0]  rsrc1,
  output logic [7:0]  ld_addr,
  output logic [7:0]  st_addr,
  output logic [15:0] imm16
);

  logic [5:0] opc;

  assign opc     = instr[F_OPC_HI:F_OPC_LO];
  assign alu_op  = opc[4:0];
  assign rdst2   = instr[F_RDST2_HI:F_RDST2_LO];
  assign rdst1   = instr[F_RDST1_HI:F_RDST1_LO];
  assign rsrc2   = instr[F_RSRC2_HI:F_RSRC2_LO];
  assign rsrc1   = instr[F_RSRC1_HI:F_RSRC1_LO];
  assign ld_addr = instr[F_LDA_HI:F_LDA_LO];
  assign st_addr = instr[F_STA_HI:F_STA_LO];
  assign imm16   = instr[F_IMM_HI:F_IMM_LO];

  always_comb begin
    cls = C_ILL;
    case (opc)
      OP_LDI: cls = C_LDI;
      OP_MOV: cls = C_MOV;
      OP_LD:  cls = C_LD;
      OP_ST:  cls = C_ST;
      OP_MUL: cls = C_MUL;
      OP_ADD, OP_SUB, OP_NEG, OP_AND, OP_OR, OP_XOR, OP_NAND,
      OP_NOR, OP_XNOR, OP_NOT, OP_SHL, OP_SHR: cls = C_ALU;
      default: cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage controller: accepts one instruction, reads operands, sequences
// the shared ALU, data-memory handshake and up to two register writebacks.
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rf_raddr_a,
  output logic [4:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        alu_start,
  output logic [4:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [7:0]  dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        busy,
  output logic        illegal
);

  // Out-of-range latencies are clamped so the 4-bit EX counter stays valid.
  localparam int unsigned LAT = (MUL_LAT < MUL_LAT_MIN) ? MUL_LAT_MIN :
                                (MUL_LAT > MUL_LAT_MAX) ? MUL_LAT_MAX : MUL_LAT;
  localparam logic [3:0] EX_LAST = 4'(LAT - 1);

  state_t      state, state_nx;
  logic [31:0] instr_q, dec_instr, res_q;
  logic [15:0] opa, opb;
  logic [3:0]  ex_cnt;
  logic        illegal_q, accept, ex_last;

  logic [2:0]  cls;
  logic [4:0]  dec_op, rdst2, rdst1, rsrc2, rsrc1;
  logic [7:0]  ld_addr, st_addr;
  logic [15:0] imm16;

  // Decode the incoming word while idle, the latched one everywhere else.
  assign dec_instr = (state == S_IDLE) ? instr : instr_q;

  exec_decode u_dec (
    .instr   (dec_instr),
    .cls     (cls),
    .alu_op  (dec_op),
    .rdst2   (rdst2),
    .rdst1   (rdst1),
    .rsrc2   (rsrc2),
    .rsrc1   (rsrc1),
    .ld_addr (ld_addr),
    .st_addr (st_addr),
    .imm16   (imm16)
  );

  assign accept  = (state == S_IDLE) && instr_valid;
  assign ex_last = (cls == C_MUL) ? (ex_cnt == EX_LAST) : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:
        if (instr_valid) begin
          case (cls)
            C_LDI:   state_nx = S_WB1;
            C_LD:    state_nx = S_MEM;
            C_ILL:   state_nx = S_IDLE;
            default: state_nx = S_RD;
          endcase
        end
      S_RD: begin
        case (cls)
          C_MOV:   state_nx = S_WB1;
          C_ST:    state_nx = S_MEM;
          default: state_nx = S_EX;
        endcase
      end
      S_EX:    if (ex_last) state_nx = S_WB1;
      S_MEM:   if (dmem_ack) state_nx = (cls == C_ST) ? S_IDLE : S_WB1;
      S_WB1:   state_nx = (cls == C_MUL) ? S_WB2 : S_IDLE;
      S_WB2:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      opa       <= '0;
      opb       <= '0;
      res_q     <= '0;
      ex_cnt    <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && (cls == C_ILL);
      if (accept) instr_q <= instr;
      if (state == S_RD) begin
        opa <= rf_rdata_a;
        opb <= rf_rdata_b;
      end
      if (state == S_EX) begin
        ex_cnt <= ex_last ? 4'd0 : ex_cnt + 4'd1;
        if (ex_last) res_q <= alu_result;
      end
      if (state == S_MEM && dmem_ack && cls == C_LD) res_q <= {16'h0, dmem_rdata};
    end
  end

  always_comb begin
    instr_ready = (state == S_IDLE);
    busy        = (state != S_IDLE);
    rf_raddr_a  = '0;
    rf_raddr_b  = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    alu_start   = 1'b0;
    alu_op      = '0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = '0;
    dmem_wdata  = '0;
    case (state)
      S_RD: begin
        rf_raddr_a = rsrc2;
        rf_raddr_b = rsrc1;
      end
      S_EX: begin
        alu_op    = dec_op;
        alu_start = (ex_cnt == 4'd0);
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = (cls == C_ST);
        dmem_addr  = (cls == C_ST) ? st_addr : ld_addr;
        dmem_wdata = (cls == C_ST) ? opb : 16'h0;
      end
      S_WB1: begin
        rf_we    = 1'b1;
        rf_waddr = (cls == C_ALU || cls == C_MUL) ? rdst1 : rdst2;
        case (cls)
          C_LDI:   rf_wdata = imm16;
          C_MOV:   rf_wdata = opb;
          default: rf_wdata = res_q[15:0];
        endcase
      end
      S_WB2: begin
        rf_we    = 1'b1;
        rf_waddr = rdst2;
        rf_wdata = res_q[31:16];
      end
      default: ;
    endcase
  end

  assign alu_a   = opa;
  assign alu_b   = opb;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed vector table, reset corner sequences and
// randomized instructions checked against a latency/effect reference model.
module tb_exec_ctrl;

  localparam int MUL_LAT = 4;
  localparam int MAXC    = 64;

  logic        clk = 1'b0, rst = 1'b1;
  logic        instr_valid, instr_ready;
  logic [31:0] instr;
  logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr, alu_op;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata, alu_a, alu_b;
  logic        rf_we, alu_start, dmem_req, dmem_we, dmem_ack, busy, illegal;
  logic [31:0] alu_result;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata;

  logic [15:0] rf  [32];
  logic [15:0] mem [256];

  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  exec_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Observations of one instruction, offsets counted from the accept cycle.
  int o_nwr, o_w0c, o_w1c, o_start, o_nstart, o_ex, o_rf, o_rcyc, o_ack, o_ill, o_nill, o_end, o_bad;
  logic [4:0]  o_w0a, o_w1a, o_op, o_ra, o_rb;
  logic [15:0] o_w0d, o_w1d, o_a, o_b, o_mwd;
  logic [7:0]  o_maddr;
  logic        o_we;

  typedef struct {
    logic [31:0] ins;
    int          ack_n;
    int          nwr;
    int          wcyc;
    logic [4:0]  waddr;
    logic [15:0] wdata;
    logic [15:0] wdata1;
    int          endc;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] d2, d1, s2, s1);
    return {op, d2, d1, 6'd0, s2, s1};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] d2, input logic [15:0] imm);
    return {op, d2, 5'd0, imm};
  endfunction

  // Behavioural ALU; non-mul ops put junk in the high half to expose misuse.
  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [15:0] a, b);
    logic [15:0] r;
    case (op)
      6'd4:  r = a + b;
      6'd5:  r = a - b;
      6'd6:  r = -a;
      6'd7:  return {16'h0, a} * {16'h0, b};
      6'd8:  r = a & b;
      6'd9:  r = a | b;
      6'd10: r = a ^ b;
      6'd11: r = ~(a & b);
      6'd12: r = ~(a | b);
      6'd13: r = ~(a ^ b);
      6'd14: r = ~a;
      6'd15: r = a << b[3:0];
      6'd16: r = a >> b[3:0];
      default: r = 16'h0;
    endcase
    return {16'hA5A5, r};
  endfunction

  task automatic issue(input logic [31:0] ins, input int ack_n, input bit noise, input string tag);
    logic [5:0]  op;
    logic [4:0]  rd2, rd1, rs2, rs1, e_w0a, e_w1a, e_ra, e_rb;
    logic [15:0] va, vb, e_w0d, e_w1d, e_mwd, req_wd;
    logic [31:0] r;
    logic [7:0]  e_maddr, req_addr;
    logic        e_we, req_we;
    int L, e_nwr, e_w0c, e_w1c, e_start, e_ex, e_rf, e_rcyc, e_ack, e_end, e_ill, rcnt, exi;
    op = ins[31:26]; rd2 = ins[25:21]; rd1 = ins[20:16]; rs2 = ins[9:5]; rs1 = ins[4:0];
    va = rf[rs2]; vb = rf[rs1];
    e_nwr = 0; e_w0c = -1; e_w1c = -1; e_w0a = 0; e_w1a = 0; e_w0d = 0; e_w1d = 0;
    e_start = -1; e_ex = 0; e_rf = -1; e_rcyc = 0; e_ack = -1; e_ill = -1; e_end = -1;
    e_ra = 0; e_rb = 0; e_we = 0; e_maddr = 0; e_mwd = 0;
    if (op == 6'd0) begin
      e_nwr = 1; e_w0c = 1; e_w0a = rd2; e_w0d = ins[15:0]; e_end = 2;
    end else if (op == 6'd1) begin
      e_ra = rs2; e_rb = rs1; e_nwr = 1; e_w0c = 2; e_w0a = rd2; e_w0d = vb; e_end = 3;
    end else if (op == 6'd2) begin
      e_rf = 1; e_rcyc = ack_n; e_ack = ack_n; e_maddr = ins[7:0];
      e_nwr = 1; e_w0c = ack_n + 1; e_w0a = rd2; e_w0d = mem[ins[7:0]]; e_end = ack_n + 2;
    end else if (op == 6'd3) begin
      e_ra = rs2; e_rb = rs1; e_rf = 2; e_rcyc = ack_n; e_ack = ack_n + 1;
      e_we = 1; e_maddr = ins[25:18]; e_mwd = vb; e_end = ack_n + 2;
    end else if (op <= 6'd16) begin
      L = (op == 6'd7) ? MUL_LAT : 1;
      r = alu_fn(op, va, vb);
      e_ra = rs2; e_rb = rs1; e_start = 2; e_ex = L;
      e_nwr = 1; e_w0c = 2 + L; e_w0a = rd1; e_w0d = r[15:0]; e_end = 3 + L;
      if (op == 6'd7) begin
        e_nwr = 2; e_w1c = 3 + L; e_w1a = rd2; e_w1d = r[31:16]; e_end = 4 + L;
      end
    end else begin
      e_ill = 1; e_end = 1;
    end

    o_nwr = 0; o_w0c = -1; o_w1c = -1; o_w0a = 0; o_w1a = 0; o_w0d = 0; o_w1d = 0;
    o_start = -1; o_nstart = 0; o_ex = 0; o_rf = -1; o_rcyc = 0; o_ack = -1;
    o_ill = -1; o_nill = 0; o_end = -1; o_bad = 0; o_op = 0; o_a = 0; o_b = 0;
    o_ra = 0; o_rb = 0; o_we = 0; o_maddr = 0; o_mwd = 0;
    req_addr = 0; req_wd = 0; req_we = 0; rcnt = 0; exi = 0;

    check({tag, ".ready_at_accept"}, {31'd0, instr_ready}, 32'd1);
    instr = ins; instr_valid = 1'b1;
    for (int k = 1; k <= MAXC; k++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      if (rf_we) begin
        o_nwr++;
        if (o_nwr == 1) begin o_w0c = k; o_w0a = rf_waddr; o_w0d = rf_wdata; end
        else if (o_nwr == 2) begin o_w1c = k; o_w1a = rf_waddr; o_w1d = rf_wdata; end
        rf[rf_waddr] = rf_wdata;
      end
      if (k == 1) begin o_ra = rf_raddr_a; o_rb = rf_raddr_b; end
      else if (rf_raddr_a != 0 || rf_raddr_b != 0) o_bad++;
      if (alu_start) begin o_nstart++; o_start = k; end
      if (alu_op != 0) begin
        exi++; o_ex++;
        if (exi == 1) begin o_op = alu_op; o_a = alu_a; o_b = alu_b; end
        else if (alu_op != o_op || alu_a != o_a || alu_b != o_b) o_bad++;
      end
      // The multiplier only delivers its product in the final EX cycle.
      alu_result = (alu_op != 0 && !(alu_op == 5'd7 && exi != MUL_LAT)) ?
                   alu_fn({1'b0, alu_op}, alu_a, alu_b) : 32'hBAD0_BAD0;
      if (dmem_req) begin
        rcnt++;
        if (rcnt == 1) begin
          o_rf = k; req_addr = dmem_addr; req_we = dmem_we; req_wd = dmem_wdata;
        end else if (dmem_addr != req_addr || dmem_we != req_we || dmem_wdata != req_wd) o_bad++;
        dmem_ack = (rcnt == ack_n);
        if (dmem_ack) begin
          o_ack = k; o_we = dmem_we; o_maddr = dmem_addr; o_mwd = dmem_wdata;
          if (dmem_we) mem[dmem_addr] = dmem_wdata;
        end
      end else begin
        dmem_ack = noise && ($urandom_range(3) == 0);
      end
      dmem_rdata = mem[dmem_addr];
      if (illegal) begin o_nill++; o_ill = k; end
      if (instr_ready && (rf_we || dmem_req)) o_bad++;
      if (busy == instr_ready) o_bad++;
      if (instr_ready) begin o_end = k; break; end
    end
    o_rcyc = rcnt;

    check({tag, ".end"}, o_end, e_end);
    check({tag, ".nwr"}, o_nwr, e_nwr);
    if (e_nwr >= 1) begin
      check({tag, ".w0cyc"}, o_w0c, e_w0c);
      check({tag, ".w0addr"}, {27'd0, o_w0a}, {27'd0, e_w0a});
      check({tag, ".w0data"}, {16'd0, o_w0d}, {16'd0, e_w0d});
    end
    if (e_nwr == 2) begin
      check({tag, ".w1cyc"}, o_w1c, e_w1c);
      check({tag, ".w1addr"}, {27'd0, o_w1a}, {27'd0, e_w1a});
      check({tag, ".w1data"}, {16'd0, o_w1d}, {16'd0, e_w1d});
    end
    check({tag, ".start"}, o_start, e_start);
    check({tag, ".nstart"}, o_nstart, (e_start >= 0) ? 1 : 0);
    check({tag, ".excyc"}, o_ex, e_ex);
    if (e_start >= 0) begin
      check({tag, ".aluop"}, {27'd0, o_op}, {27'd0, op[4:0]});
      check({tag, ".alua"}, {16'd0, o_a}, {16'd0, va});
      check({tag, ".alub"}, {16'd0, o_b}, {16'd0, vb});
    end
    check({tag, ".raddr"}, {22'd0, o_ra, o_rb}, {22'd0, e_ra, e_rb});
    check({tag, ".reqfirst"}, o_rf, e_rf);
    check({tag, ".reqcyc"}, o_rcyc, e_rcyc);
    if (e_rf >= 0) begin
      check({tag, ".ackcyc"}, o_ack, e_ack);
      check({tag, ".dmem_we"}, {31'd0, o_we}, {31'd0, e_we});
      check({tag, ".dmem_addr"}, {24'd0, o_maddr}, {24'd0, e_maddr});
      if (e_we) check({tag, ".dmem_wdata"}, {16'd0, o_mwd}, {16'd0, e_mwd});
    end
    check({tag, ".illcyc"}, o_ill, e_ill);
    check({tag, ".nill"}, o_nill, (e_ill >= 0) ? 1 : 0);
    check({tag, ".protocol"}, o_bad, 0);
  endtask

  logic [31:0] ins;
  int          sel, quiet;

  initial begin
    instr_valid = 1'b0; instr = '0; alu_result = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    for (int i = 0; i < 32; i++) rf[i] = 16'($urandom);
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rf[5] = 16'h1234; rf[6] = 16'h0F0F; rf[1] = 16'h0100; rf[2] = 16'h0300;
    rf[4] = 16'h5A5A; mem[8'h2A] = 16'hC0DE;

    repeat (3) @(negedge clk);
    check("reset.ready", {31'd0, instr_ready}, 32'd1);
    check("reset.zero", {31'd0, |{busy, rf_we, rf_waddr, rf_wdata, alu_start, alu_op, alu_a, alu_b,
                                 dmem_req, dmem_we, dmem_addr, dmem_wdata, illegal,
                                 rf_raddr_a, rf_raddr_b}}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{enc_i(6'd0, 5'd3, 16'hBEEF),         1, 1, 1, 5'd3,  16'hBEEF, 16'h0,    2};
    vecs[1] = '{enc_r(6'd4, 5'd0, 5'd7, 5'd5, 5'd6), 1, 1, 3, 5'd7,  16'h2143, 16'h0,    4};
    vecs[2] = '{enc_r(6'd7, 5'd9, 5'd8, 5'd1, 5'd2), 1, 2, 6, 5'd8,  16'h0000, 16'h0003, 8};
    vecs[3] = '{enc_i(6'd2, 5'd10, 16'h002A),        3, 1, 4, 5'd10, 16'hC0DE, 16'h0,    5};
    vecs[4] = '{{6'd3, 8'hFF, 13'd0, 5'd4},          2, 0, 0, 5'd0,  16'h0,    16'h0,    4};
    vecs[5] = '{32'hFC00_0000,                       1, 0, 0, 5'd0,  16'h0,    16'h0,    1};
    vecs[6] = '{enc_r(6'd1, 5'd11, 5'd0, 5'd0, 5'd5),1, 1, 2, 5'd11, 16'h1234, 16'h0,    3};

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].ins, vecs[i].ack_n, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_end", i), o_end, vecs[i].endc);
      check($sformatf("vec%0d.tbl_nwr", i), o_nwr, vecs[i].nwr);
      if (vecs[i].nwr > 0) begin
        check($sformatf("vec%0d.tbl_wcyc", i), o_w0c, vecs[i].wcyc);
        check($sformatf("vec%0d.tbl_waddr", i), {27'd0, o_w0a}, {27'd0, vecs[i].waddr});
        check($sformatf("vec%0d.tbl_wdata", i), {16'd0, o_w0d}, {16'd0, vecs[i].wdata});
      end
      if (vecs[i].nwr == 2)
        check($sformatf("vec%0d.tbl_wdata1", i), {16'd0, o_w1d}, {16'd0, vecs[i].wdata1});
    end
    check("st.mem_written", {16'd0, mem[8'hFF]}, {16'd0, 16'h5A5A});

    // Reset during the second EX cycle of a multiply.
    instr = enc_r(6'd7, 5'd9, 5'd8, 5'd1, 5'd2); instr_valid = 1'b1; dmem_ack = 1'b0;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmul.in_ex2", {27'd0, alu_op, alu_start}, {27'd7, 1'b0});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmul.idle", {29'd0, instr_ready, busy, rf_we}, {29'd0, 3'b100});
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (rf_we || dmem_req || alu_start || busy) quiet++;
    end
    check("rstmul.quiet", quiet, 0);

    // Reset with a load request outstanding.
    instr = enc_i(6'd2, 5'd12, 16'h0010); instr_valid = 1'b1;
    @(negedge clk); instr_valid = 1'b0;
    check("rstld.req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstld.drop", {30'd0, dmem_req, instr_ready}, {30'd0, 2'b01});
    issue(enc_i(6'd0, 5'd13, 16'h7E57), 1, 1'b0, "after_rst");

    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom_range(19));
      ins = $urandom;
      ins[31:26] = (sel <= 16) ? 6'(sel) : 6'($urandom_range(63, 17));
      issue(ins, int'($urandom_range(4, 1)), 1'b1, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Multi-cycle execute-stage controller for the 16-bit Harvard core. It accepts one 32-bit instruction at a time over a valid/ready handshake and reads source registers. It then sequences the shared ALU (single-cycle ops plus the multi-cycle carry-save multiplier), drives data-memory load/store handshakes, and issues register-file writebacks over a single write port. It sits between instruction decode/fetch and the register file, ALU and data memory.

## Interface
- `MUL_LAT`, default 4: cycles the multiplier needs, counted from `alu_start`. Legal range is 1..15.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  high only in IDLE.
- `instr`  in  32  opcode is [31:26]; fields as listed under Operation.
- `rf_raddr_a`, `rf_raddr_b`  out  5 each  register read addresses. Read is combinational: data is valid in the same cycle.
- `rf_rdata_a`, `rf_rdata_b`  in  16 each  read data.
- `rf_we`  out  1  write strobe.
- `rf_waddr`  out  5  write address.
- `rf_wdata`  out  16  write data.
- `alu_start`  out  1  one-cycle pulse on the first EX cycle.
- `alu_op`  out  5  equals opcode[4:0] during EX; 0 otherwise.
- `alu_a`, `alu_b`  out  16 each  operand registers, held stable for all of EX.
- `alu_result`  in  32  ALU result; only the multiplier uses bits [31:16].
- `dmem_req`  out  1  memory request; held until `dmem_ack`.
- `dmem_we`  out  1  write (store) qualifier.
- `dmem_addr`  out  8  memory address.
- `dmem_wdata`  out  16  store data.
- `dmem_rdata`  in  16  load data, valid with `dmem_ack`.
- `dmem_ack`  in  1  memory handshake complete.
- `busy`  out  1  high when not in IDLE.
- `illegal`  out  1  one-cycle pulse for an undefined opcode.

## Operation
- **Field names:**
  - Rdst2 = [25:21]
  - Rdst1 = [20:16]
  - Rsrc2 = [9:5]
  - Rsrc1 = [4:0]
  - imm16 = [15:0]
- **Opcodes:**
  - 000000 LDI: Rdst2 ← imm16.
  - 000001 MOV: Rdst2 ← R[Rsrc1].
  - 000010 LD: Rdst2 ← mem[instr[7:0]].
  - 000011 ST: mem[instr[25:18]] ← R[Rsrc1].
  - 000100..010000: ALU ops in this order: add, sub, neg, mul, and, or, xor, nand, nor, xnor, not, shl, shr.
    - `alu_a` = R[Rsrc2], `alu_b` = R[Rsrc1].
    - Result [15:0] goes to Rdst1.
    - mul additionally writes [31:16] to Rdst2.
  - Opcodes 010001..111111 are illegal.
- **States:** IDLE, RD, EX, MEM, WB1, WB2.
- **Transitions out of IDLE** (taken when `instr_valid` is high; instr is latched on accept):
  - LDI→WB1.
  - LD→MEM.
  - Illegal→IDLE, with `illegal` pulsed the next cycle.
  - All others→RD.
- **RD:** drives `rf_raddr_a`=Rsrc2 and `rf_raddr_b`=Rsrc1, and captures both read data words into the operand registers.
  - MOV→WB1.
  - ST→MEM.
  - ALU→EX.
- **EX:** a 4-bit counter holds EX for L cycles, with L = `MUL_LAT` for mul and 1 otherwise.
  - `alu_result` is captured in the last EX cycle.
  - Next state is WB1.
- **MEM:** `dmem_req` is held high with constant address, data and `dmem_we` until the cycle `dmem_ack` is high.
  - LD captures `dmem_rdata` in that cycle and goes to WB1.
  - ST goes to IDLE.
  - `dmem_ack` outside MEM is ignored.
- **WB1:** `rf_we`=1 with the single-cycle destination: Rdst2 for LDI/MOV/LD, Rdst1 for ALU ops.
  - mul→WB2, where `rf_we`=1 with Rdst2 and result[31:16].
  - Otherwise→IDLE.
- **mul with Rdst1==Rdst2:** both writes occur in order, so the high half remains.
- **Register read addresses:** are 0 outside RD.

## Timing
- **Reset:** all outputs are 0 except `instr_ready`=1. State is IDLE, counters and latches are cleared.
- **Reset mid-operation:** the next cycle is IDLE, with no write or memory strobe issued after the `rst` edge. An in-flight `dmem_req` drops.
- **Latency**, with accept in cycle A:
  - LDI: write in A+1.
  - MOV: write in A+2.
  - ALU: `alu_start` in A+2, WB1 in A+2+L, WB2 in A+3+L for mul.
  - LD: `dmem_req` from A+1; write in ack cycle K+1.
  - ST: `dmem_req` from A+2; IDLE at K+1.
- **Issue rate:** back-to-back accepts are possible; the earliest next accept is the cycle after the final state. LDI sustains one instruction every 2 cycles.
- `instr_ready` never goes high in the same cycle as `rf_we` or `dmem_req`.

## Structure
- **Package `exec_pkg`:**
  - opcode localparams (OP_LDI … OP_SHR)
  - state enum
  - field bit-position constants
  - `MUL_LAT` bounds
- **Sub-module `exec_decode`** (combinational): instr → class (LDI/MOV/LD/ST/ALU/MUL/ILLEGAL), the register fields, both memory addresses and imm16.
- The FSM, EX counter and output registers live in `exec_ctrl`.

## Test plan
1. **LDI:** reset, then LDI Rdst2=3, imm=0xBEEF → single `rf_we` in A+1 with waddr 3, wdata 0xBEEF; `busy` for 1 cycle.
2. **add:** with R5=0x1234 and R6=0x0F0F, add Rdst1=7 Rsrc2=5 Rsrc1=6, ALU model returning the sum → `alu_start` at A+2 with a=0x1234, b=0x0F0F, `alu_op`=00100; write R7=0x2143 at A+3.
3. **mul:** `MUL_LAT`=4, R1=0x0100, R2=0x0300, mul Rdst1=8 Rdst2=9, model returns 0x00030000 after 4 cycles → EX for exactly 4 cycles; R8←0x0000 at A+6, R9←0x0003 at A+7.
4. **Load/store with delayed ack:** LD addr 0x2A with ack delayed 3 cycles → req held constant for 3 cycles, then write of `dmem_rdata`. ST addr 0xFF from R4 → `dmem_we`=1, addr 0xFF, no `rf_we`.
5. **Illegal opcode:** opcode 111111 → `illegal` pulse at A+1; no rf/dmem/alu strobes; next instruction accepted at A+1.
6. **Reset mid-multiply:** `rst` asserted in the 2nd EX cycle of a mul → IDLE the next cycle, no WB1/WB2 writes, `instr_ready`=1.
